gshare_ras_predictor: RTL and testbench

- Parametrised front-end predictor for the 5-stage RV32I core, replacing the inline fixed gshare table.
- Contains:
  - a gshare BHT with configurable table and history size and a self-clearing reset sequencer;
  - a return-address stack (RAS), so `ret`-style JALRs are predicted instead of always redirecting from execute.
- The decode stage looks up the predictor; the execute stage trains it and restores the RAS on redirect.

---
 rtl/gshare_ras_predictor.sv | 219 +++++++++++++++++++++
 tb/tb_gshare_ras_predictor.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_ras_predictor.sv
// gshare_ras_predictor
// Front-end branch predictor for the 5-stage RV32I core: a gshare table of
// 2-bit counters indexed by PC xor global history, plus a return-address
// stack so that returns are predicted at decode.
//
// Ports
//   clk, resetn   clock, synchronous active-low reset
//   ready         high once the BHT has been cleared after reset
//   p_valid       decode lookup accepted (drives RAS push/pop)
//   p_pc, p_instr decode PC and instruction word
//   p_taken       predicted redirect
//   p_target      predicted next PC
//   p_index       BHT index of this lookup, carried down to u_index
//   p_snap        RAS {tos, count} before this lookup's effect
//   u_valid       execute resolved a conditional branch
//   u_index       BHT index carried from lookup
//   u_taken       resolved outcome
//   f_valid       execute redirect; RAS pointer state restored from f_snap
//   f_snap        {tos, count} to restore
module gshare_ras_predictor #(
  parameter int BHT_ADDR_BITS = 12,
  parameter int HIST_BITS     = 12,
  parameter int RAS_DEPTH     = 8,
  localparam int PW = $clog2(RAS_DEPTH),
  localparam int CW = $clog2(RAS_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  output logic                     ready,
  input  logic                     p_valid,
  input  logic [31:0]              p_pc,
  input  logic [31:0]              p_instr,
  output logic                     p_taken,
  output logic [31:0]              p_target,
  output logic [BHT_ADDR_BITS-1:0] p_index,
  output logic [PW+CW-1:0]         p_snap,
  input  logic                     u_valid,
  input  logic [BHT_ADDR_BITS-1:0] u_index,
  input  logic                     u_taken,
  input  logic                     f_valid,
  input  logic [PW+CW-1:0]         f_snap
);

  localparam int BHT_ENTRIES = 2 ** BHT_ADDR_BITS;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                   state_q, state_d;
  logic                     ready_q, ready_d;
  logic [BHT_ADDR_BITS-1:0] clr_q, clr_d;
  logic [HIST_BITS-1:0]     gh_q, gh_d;
  logic [PW-1:0]            tos_q, tos_d;
  logic [CW-1:0]            cnt_q, cnt_d;

  logic [1:0]  bht_mem [BHT_ENTRIES];
  logic [31:0] ras_mem [RAS_DEPTH];

  logic                     bht_we;
  logic [BHT_ADDR_BITS-1:0] bht_waddr;
  logic [1:0]               bht_wdata;
  logic [1:0]               bht_cur;

  logic          ras_we;
  logic [PW-1:0] ras_waddr;
  logic [31:0]   ras_wdata;

  // ---------------------------------------------------------------- decode
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1;
  logic        is_br, is_jal, is_jalr;
  logic        rd_link, rs1_link;
  logic        is_call, is_ret, is_callret;
  logic [31:0] b_imm, j_imm;
  logic [31:0] pc_plus4;

  always_comb begin
    opcode   = p_instr[6:0];
    rd       = p_instr[11:7];
    rs1      = p_instr[19:15];
    is_br    = (opcode == 7'b1100011);
    is_jal   = (opcode == 7'b1101111);
    is_jalr  = (opcode == 7'b1100111);
    rd_link  = (rd == 5'd1) || (rd == 5'd5);
    rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);
    // A JALR with both link registers is a coroutine swap: pop then push,
    // which collapses to overwriting the top entry.
    is_callret = is_jalr && rd_link && rs1_link;
    is_call    = (is_jal || is_jalr) && rd_link && !is_callret;
    is_ret     = is_jalr && !rd_link && rs1_link;
    b_imm    = {{19{p_instr[31]}}, p_instr[31], p_instr[7], p_instr[30:25],
                p_instr[11:8], 1'b0};
    j_imm    = {{11{p_instr[31]}}, p_instr[31], p_instr[19:12], p_instr[20],
                p_instr[30:21], 1'b0};
    pc_plus4 = p_pc + 32'd4;
  end

  // ------------------------------------------------------------- prediction
  logic [BHT_ADDR_BITS-1:0] gh_ext;

  always_comb begin
    gh_ext                = '0;
    gh_ext[HIST_BITS-1:0] = gh_q;
  end

  assign p_index = p_pc[BHT_ADDR_BITS+1:2] ^ gh_ext;
  assign p_snap  = {tos_q, cnt_q};
  assign ready   = ready_q;

  always_comb begin
    p_taken  = 1'b0;
    p_target = pc_plus4;
    if (ready_q) begin
      if (is_br) begin
        // Asynchronous read: a same-cycle training write is not visible.
        if (bht_mem[p_index][1]) begin
          p_taken  = 1'b1;
          p_target = p_pc + b_imm;
        end
      end else if (is_jal) begin
        p_taken  = 1'b1;
        p_target = p_pc + j_imm;
      end else if (is_ret && (cnt_q != '0)) begin
        p_taken  = 1'b1;
        p_target = ras_mem[tos_q];
      end
    end
  end

  // ------------------------------------------- sequencer, BHT train, history
  assign bht_cur = bht_mem[u_index];

  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    clr_d     = clr_q;
    gh_d      = gh_q;
    bht_we    = 1'b0;
    bht_waddr = clr_q;
    bht_wdata = 2'b01;
    case (state_q)
      ST_INIT: begin
        // Sweep every entry to weakly-not-taken before predictions are used.
        bht_we = 1'b1;
        clr_d  = clr_q + 1'b1;
        if (clr_q == '1) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end
      end
      default: begin
        if (u_valid) begin
          bht_we    = 1'b1;
          bht_waddr = u_index;
          if (u_taken) bht_wdata = (bht_cur == 2'b11) ? 2'b11 : bht_cur + 2'd1;
          else         bht_wdata = (bht_cur == 2'b00) ? 2'b00 : bht_cur - 2'd1;
          gh_d = (gh_q << 1) | HIST_BITS'(u_taken);
        end
      end
    endcase
  end

  // --------------------------------------------------------------- RAS ctrl
  always_comb begin
    tos_d     = tos_q;
    cnt_d     = cnt_q;
    ras_we    = 1'b0;
    ras_waddr = tos_q + PW'(1);
    ras_wdata = pc_plus4;
    if (ready_q) begin
      // A redirect wins over any same-cycle decode effect.
      if (f_valid) begin
        {tos_d, cnt_d} = f_snap;
      end else if (p_valid) begin
        if (is_callret) begin
          ras_we    = 1'b1;
          ras_waddr = tos_q;
        end else if (is_call) begin
          // When full the pointer simply wraps over the oldest entry.
          ras_we = 1'b1;
          tos_d  = tos_q + PW'(1);
          if (cnt_q != CW'(RAS_DEPTH)) cnt_d = cnt_q + CW'(1);
        end else if (is_ret && (cnt_q != '0)) begin
          tos_d = tos_q - PW'(1);
          cnt_d = cnt_q - CW'(1);
        end
      end
    end
  end

  // ------------------------------------------------------------------ state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_INIT;
      ready_q <= 1'b0;
      clr_q   <= '0;
      gh_q    <= '0;
      tos_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      clr_q   <= clr_d;
      gh_q    <= gh_d;
      tos_q   <= tos_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage arrays carry no reset; the BHT is cleared by the INIT sweep and
  // RAS slots are only read after a push has written them.
  always_ff @(posedge clk) begin
    if (resetn && bht_we) bht_mem[bht_waddr] <= bht_wdata;
  end

  always_ff @(posedge clk) begin
    if (resetn && ras_we) ras_mem[ras_waddr] <= ras_wdata;
  end

endmodule

// File: tb/tb_gshare_ras_predictor.sv
module tb_gshare_ras_predictor;

  localparam int AB = 4;
  localparam int HB = 4;
  localparam int RD = 4;
  localparam int NENT = 16;

  localparam int K_OTHER = 0;
  localparam int K_BR    = 1;
  localparam int K_JAL   = 2;
  localparam int K_JALR  = 3;

  logic          clk = 1'b0;
  logic          resetn;
  logic          ready;
  logic          p_valid;
  logic [31:0]   p_pc;
  logic [31:0]   p_instr;
  logic          p_taken;
  logic [31:0]   p_target;
  logic [AB-1:0] p_index;
  logic [4:0]    p_snap;
  logic          u_valid;
  logic [AB-1:0] u_index;
  logic          u_taken;
  logic          f_valid;
  logic [4:0]    f_snap;

  gshare_ras_predictor #(.BHT_ADDR_BITS(AB), .HIST_BITS(HB), .RAS_DEPTH(RD)) dut (
    .clk(clk), .resetn(resetn), .ready(ready),
    .p_valid(p_valid), .p_pc(p_pc), .p_instr(p_instr),
    .p_taken(p_taken), .p_target(p_target), .p_index(p_index), .p_snap(p_snap),
    .u_valid(u_valid), .u_index(u_index), .u_taken(u_taken),
    .f_valid(f_valid), .f_snap(f_snap)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  // current instruction, described abstractly
  int k_kind, k_rd, k_rs1, k_imm;

  // reference model
  int          m_bht [NENT];
  logic [31:0] m_ras [RD];
  int          m_tos, m_cnt, m_gh, m_clr;
  bit          m_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_link(input int r);
    return (r == 1) || (r == 5);
  endfunction

  task automatic set_instr(input int kind, input int rd, input int rs1, input int imm);
    logic [31:0] iv;
    logic [4:0]  r_d, r_s;
    iv = imm; r_d = rd[4:0]; r_s = rs1[4:0];
    k_kind = kind; k_rd = rd; k_rs1 = rs1; k_imm = imm;
    case (kind)
      K_BR:    p_instr = {iv[12], iv[10:5], 5'd2, 5'd10, 3'b001, iv[4:1], iv[11], 7'b1100011};
      K_JAL:   p_instr = {iv[20], iv[10:1], iv[11], iv[19:12], r_d, 7'b1101111};
      K_JALR:  p_instr = {iv[11:0], r_s, 3'b000, r_d, 7'b1100111};
      default: p_instr = {iv[11:0], r_s, 3'b000, r_d, 7'b0010011};
    endcase
  endtask

  task automatic model_expect(output logic e_taken, output logic [31:0] e_tgt);
    int idx;
    e_taken = 1'b0;
    e_tgt   = p_pc + 32'd4;
    if (m_ready) begin
      idx = ((p_pc >> 2) & 15) ^ m_gh;
      if (k_kind == K_BR) begin
        if (m_bht[idx] >= 2) begin e_taken = 1'b1; e_tgt = p_pc + 32'(k_imm); end
      end else if (k_kind == K_JAL) begin
        e_taken = 1'b1; e_tgt = p_pc + 32'(k_imm);
      end else if (k_kind == K_JALR && !is_link(k_rd) && is_link(k_rs1) && m_cnt > 0) begin
        e_taken = 1'b1; e_tgt = m_ras[m_tos];
      end
    end
  endtask

  task automatic model_update();
    bit call, ret;
    int i;
    if (!resetn) begin
      m_ready = 0; m_clr = 0; m_gh = 0; m_tos = 0; m_cnt = 0;
    end else if (!m_ready) begin
      m_bht[m_clr] = 1;
      m_clr++;
      if (m_clr == NENT) m_ready = 1;
    end else begin
      if (u_valid) begin
        i = u_index;
        if (u_taken) m_bht[i] = (m_bht[i] < 3) ? m_bht[i] + 1 : 3;
        else         m_bht[i] = (m_bht[i] > 0) ? m_bht[i] - 1 : 0;
        m_gh = ((m_gh << 1) | u_taken) & 15;
      end
      if (f_valid) begin
        m_tos = f_snap[4:3];
        m_cnt = f_snap[2:0];
      end else if (p_valid) begin
        call = (k_kind == K_JAL || k_kind == K_JALR) && is_link(k_rd);
        ret  = (k_kind == K_JALR) && is_link(k_rs1);
        if (call && ret) begin
          m_ras[m_tos] = p_pc + 32'd4;
        end else if (call) begin
          m_tos = (m_tos + 1) % RD;
          m_ras[m_tos] = p_pc + 32'd4;
          m_cnt = (m_cnt < RD) ? m_cnt + 1 : RD;
        end else if (ret && m_cnt > 0) begin
          m_tos = (m_tos + RD - 1) % RD;
          m_cnt--;
        end
      end
    end
  endtask

  // Check lookup outputs mid-cycle, then advance one edge and the model.
  task automatic tick();
    logic        e_taken;
    logic [31:0] e_tgt;
    logic [3:0]  e_idx, gh4;
    logic [4:0]  e_snap;
    logic [1:0]  t2;
    logic [2:0]  c3;
    @(negedge clk);
    if (chk_en) begin
      model_expect(e_taken, e_tgt);
      gh4 = m_gh[3:0];
      e_idx = p_pc[5:2] ^ gh4;
      t2 = m_tos[1:0]; c3 = m_cnt[2:0];
      e_snap = {t2, c3};
      chk("ready", 32'(ready), 32'(m_ready));
      chk("p_index", 32'(p_index), 32'(e_idx));
      chk("p_snap", 32'(p_snap), 32'(e_snap));
      chk("p_taken", 32'(p_taken), 32'(e_taken));
      chk("p_target", p_target, e_tgt);
    end
    @(posedge clk);
    model_update();
    chk_en = 1;
    #1;
  endtask

  task automatic idle();
    p_valid = 0; u_valid = 0; u_taken = 0; u_index = '0; f_valid = 0; f_snap = '0;
    p_pc = 32'h0; set_instr(K_OTHER, 0, 0, 0);
  endtask

  task automatic lookup_idx0();
    p_valid = 1;
    p_pc = 32'h100 | (32'(m_gh) << 2);
    set_instr(K_BR, 0, 0, 32'h40);
  endtask

  function automatic int pick_reg();
    case ($urandom % 4)
      0: return 1;
      1: return 5;
      2: return 0;
      default: return int'($urandom % 32);
    endcase
  endfunction

  initial begin : main
    int outcomes [10];
    int exp_pred [10];
    logic [31:0] ret_tgt [4];
    int wait_cnt;
    outcomes = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1};
    exp_pred = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    ret_tgt  = '{32'h54, 32'h44, 32'h34, 32'h24};

    idle();
    resetn = 0;
    repeat (3) tick();

    // reset clear: ready low for 16 cycles after release
    resetn = 1;
    for (int i = 0; i < 16; i++) begin
      chk("ready_lo", 32'(ready), 32'd0);
      tick();
    end
    chk("ready_hi", 32'(ready), 32'd1);

    p_valid = 1; p_pc = 32'h100; set_instr(K_BR, 0, 0, 32'h40);
    #1;
    chk("bne_cleared_taken", 32'(p_taken), 32'd0);
    chk("bne_cleared_target", p_target, 32'h104);
    tick();

    // training on index 0 with history replay
    for (int i = 0; i < 10; i++) begin
      lookup_idx0();
      u_valid = 1; u_index = '0; u_taken = outcomes[i][0];
      #1;
      chk("train_pred", 32'(p_taken), 32'(exp_pred[i]));
      if (exp_pred[i] == 1) chk("train_target", p_target, p_pc + 32'h40);
      tick();
    end
    u_valid = 0;

    // call / return
    p_valid = 1; p_pc = 32'h200; set_instr(K_JAL, 1, 0, 32'h100);
    #1; chk("jal_target", p_target, 32'h300);
    tick();
    p_pc = 32'h300; set_instr(K_JALR, 0, 1, 0);
    #1; chk("ret_taken", 32'(p_taken), 32'd1); chk("ret_target", p_target, 32'h204);
    tick();
    p_pc = 32'h304;
    #1; chk("ret_empty_taken", 32'(p_taken), 32'd0); chk("ret_empty_target", p_target, 32'h308);
    tick();

    // overflow of a 4-deep RAS
    for (int i = 1; i <= 5; i++) begin
      p_pc = 32'(i * 16); set_instr(K_JAL, 1, 0, 8);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      p_pc = 32'h1000 + 32'(i * 4); set_instr(K_JALR, 0, 5, 0);
      #1;
      if (i < 4) begin
        chk("ovf_taken", 32'(p_taken), 32'd1);
        chk("ovf_target", p_target, ret_tgt[i]);
      end else begin
        chk("ovf_empty_taken", 32'(p_taken), 32'd0);
      end
      tick();
    end

    // flush priority over a same-cycle call
    p_pc = 32'h600; set_instr(K_JAL, 1, 0, 8);
    f_valid = 1; f_snap = 5'b01_001;
    tick();
    f_valid = 0;
    p_pc = 32'h700; set_instr(K_JALR, 0, 1, 0);
    #1;
    chk("flush_snap", 32'(p_snap), 32'h09);
    chk("flush_ret_target", p_target, 32'h54);
    tick();

    // randomized run with a mid-run reset
    for (int n = 0; n < 400; n++) begin
      int kind, imm;
      kind = int'($urandom % 4);
      case (kind)
        K_BR:    imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
        K_JAL:   imm = (int'($urandom_range(0, 1048575)) - 524288) * 2;
        default: imm = int'($urandom % 4096);
      endcase
      p_pc    = $urandom & 32'hFFFF_FFFC;
      set_instr(kind, pick_reg(), pick_reg(), imm);
      p_valid = ($urandom % 4) != 0;
      u_valid = $urandom % 2;
      u_index = 4'($urandom);
      u_taken = $urandom % 2;
      f_valid = ($urandom % 10) == 0;
      f_snap  = {2'($urandom), 3'($urandom_range(0, 4))};
      resetn  = (n != 200);
      tick();
      if (n == 200) begin
        chk("midrst_ready", 32'(ready), 32'd0);
        chk("midrst_snap", 32'(p_snap), 32'd0);
        chk("midrst_gh", 32'(p_index), 32'(p_pc[5:2]));
      end
    end

    // ready must come back after the re-clear
    idle();
    wait_cnt = 0;
    while (ready !== 1'b1 && wait_cnt < 40) begin tick(); wait_cnt++; end
    chk("ready_return", 32'(ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
